// File: rtl/d_mem_seq.sv
// Data-memory access sequencer: drives a req/gnt/rvalid port, steers byte lanes and
// sign/zero-extends loads. Define MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module d_mem_seq #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_mem_rd_en,
  input  logic        d_mem_wr_en,
  input  logic [1:0]  d_mem_size,
  input  logic        ld_unsigned,
  input  logic [31:0] d_mem_addr,
  input  logic [31:0] d_mem_wr_data,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        done,
  output logic        bus_err,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_err,
`endif
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]  ld_size_q, ld_size_d;
  logic [1:0]  ld_off_q, ld_off_d;
  logic        ld_uns_q, ld_uns_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        done_q, done_d;
  logic        bus_err_q, bus_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        acc_req;
  logic        acc_we;
  logic        misalign;
  logic [1:0]  acc_off;
  logic [3:0]  acc_be;
  logic [31:0] acc_wdata;
  logic [15:0] ld_lane;
  logic [31:0] ld_ext;

  // Request decode: a simultaneous rd/wr is a load; misaligned low bits are dropped.
  always_comb begin
    acc_req   = d_mem_rd_en | d_mem_wr_en;
    acc_we    = d_mem_wr_en & ~d_mem_rd_en;
    acc_off   = d_mem_addr[1:0];
    acc_be    = 4'b1111;
    acc_wdata = d_mem_wr_data;
    case (d_mem_size)
      2'b00: begin
        // NOTE: blocking '=' inside always_comb, so acc_off is read back in the same pass;
        // every target gets a default above so no latch is inferred.
        acc_be    = 4'b0001 << acc_off;
        acc_wdata = {4{d_mem_wr_data[7:0]}};
      end
      2'b01: begin
        acc_off[0] = 1'b0;
        acc_be     = d_mem_addr[1] ? 4'b1100 : 4'b0011;
        acc_wdata  = {2{d_mem_wr_data[15:0]}};
      end
      default: acc_off = 2'b00;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  assign misalign = (d_mem_size == 2'b01) ? d_mem_addr[0]
                  : ((d_mem_size != 2'b00) && (d_mem_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Load lane select from the offset/size captured at request time.
  always_comb begin
    ld_lane = 16'(mem_rdata >> {ld_off_q, 3'b000});
    case (ld_size_q)
      2'b00:   ld_ext = {{24{ld_lane[7] & ~ld_uns_q}}, ld_lane[7:0]};
      2'b01:   ld_ext = {{16{ld_lane[15] & ~ld_uns_q}}, ld_lane};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    ld_size_d   = ld_size_q;
    ld_off_d    = ld_off_q;
    ld_uns_d    = ld_uns_q;
    rd_data_d   = rd_data_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    bus_err_d   = 1'b0;
    stall       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (acc_req) begin
          if (misalign) begin
            done_d = 1'b1;
          end else begin
            stall       = 1'b1;
            state_d     = S_REQ;
            mem_we_d    = acc_we;
            mem_addr_d  = {d_mem_addr[31:2], 2'b00};
            mem_be_d    = acc_be;
            mem_wdata_d = acc_wdata;
            ld_size_d   = d_mem_size;
            ld_off_d    = acc_off;
            ld_uns_d    = ld_unsigned;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (mem_gnt) begin
          if (mem_we_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 16'd0;
          end
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        // rvalid on the final allowed cycle still retires the load cleanly.
        if (mem_rvalid) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          rd_data_d = ld_ext;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          bus_err_d = 1'b1;
          rd_data_d = 32'd0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
  end

  // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= 32'd0;
      ld_size_q   <= 2'd0;
      ld_off_q    <= 2'd0;
      ld_uns_q    <= 1'b0;
      rd_data_q   <= 32'd0;
      done_q      <= 1'b0;
      bus_err_q   <= 1'b0;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      ld_size_q   <= ld_size_d;
      ld_off_q    <= ld_off_d;
      ld_uns_q    <= ld_uns_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      bus_err_q   <= bus_err_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_err_q, misalign_err_d;

  assign misalign_err_d = (state_q == S_IDLE) & acc_req & misalign;

  always_ff @(posedge clk) begin
    if (rst) misalign_err_q <= 1'b0;
    else     misalign_err_q <= misalign_err_d;
  end

  assign misalign_err = misalign_err_q;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_d_mem_seq.sv
// Self-checking bench for d_mem_seq: directed scenarios plus randomized accesses checked
// against an arithmetic reference model of lane steering, extension and timeout.
module tb_d_mem_seq;

  localparam int TO = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en, ld_unsigned;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        stall, done, bus_err, mem_req, mem_we;
  logic [31:0] rd_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rd;

  always #5 clk = ~clk;

  d_mem_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .d_mem_rd_en   (rd_en),
    .d_mem_wr_en   (wr_en),
    .d_mem_size    (size),
    .ld_unsigned   (ld_unsigned),
    .d_mem_addr    (addr),
    .d_mem_wr_data (wdata),
    .stall         (stall),
    .rd_data       (rd_data),
    .done          (done),
    .bus_err       (bus_err),
`ifdef MISALIGN_TRAP_EN
    .misalign_err  (misalign_err),
`endif
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_be        (mem_be),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  // ---------------- reference model ----------------
  function automatic int eff_off(input logic [1:0] sz, input logic [31:0] a);
    int o;
    o = int'(a % 32'd4);
    if (sz == 2'b01) return o - (o % 2);
    if (sz != 2'b00) return 0;
    return o;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 4'(1 << eff_off(sz, a));
    if (sz == 2'b01) return 4'(3 << eff_off(sz, a));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'b00) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2'b01) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a, input logic [31:0] w);
    int nb;
    logic [63:0] v, m;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    m  = (64'd1 << (8 * nb)) - 64'd1;
    v  = ({32'd0, w} >> (8 * eff_off(sz, a))) & m;
    if (!uns && nb < 4 && v[8*nb-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access; gnt_dly = extra REQ cycles, rv_dly = WAIT cycle index of rvalid
  // (>= TO means rvalid never arrives). Starts and ends one step after a rising edge in IDLE.
  task automatic run_access(input logic rd, input logic wr, input logic [1:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] d,
                            input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                            input string tag);
    logic        exp_we, exp_err;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    exp_we   = wr & ~rd;
    exp_err  = 1'b0;
    exp_addr = a & ~32'h3;
    exp_be   = m_be(sz, a);

    rd_en = rd; wr_en = wr; size = sz; ld_unsigned = uns; addr = a; wdata = d;
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL %s idle_stall got=%b exp=1", tag, stall); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL %s idle_req got=%b exp=0", tag, mem_req); end
    tick();

    for (int g = 0; g <= gnt_dly; g++) begin
      mem_gnt = (g == gnt_dly);
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL %s req got=%b exp=1", tag, mem_req); end
      checks++; if (stall !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL %s req_stall_done got=%b%b exp=10", tag, stall, done); end
      checks++; if (mem_we !== exp_we) begin errors++; $display("FAIL %s we got=%b exp=%b", tag, mem_we, exp_we); end
      checks++; if (mem_addr !== exp_addr) begin errors++; $display("FAIL %s addr got=%h exp=%h", tag, mem_addr, exp_addr); end
      checks++; if (mem_be !== exp_be) begin errors++; $display("FAIL %s be got=%b exp=%b", tag, mem_be, exp_be); end
      if (exp_we) begin
        checks++; if (mem_wdata !== m_wdata(sz, d)) begin errors++; $display("FAIL %s wdata got=%h exp=%h", tag, mem_wdata, m_wdata(sz, d)); end
      end
      checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL %s rd_hold got=%h exp=%h", tag, rd_data, last_rd); end
      tick();
    end
    mem_gnt = 1'b0;

    if (!exp_we) begin
      for (int w = 0; w < TO; w++) begin
        mem_rvalid = (w == rv_dly);
        mem_rdata  = (w == rv_dly) ? rdata : $urandom();
        @(negedge clk);
        checks++; if (stall !== 1'b1 || mem_req !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL %s wait stall/req/done got=%b%b%b exp=100", tag, stall, mem_req, done); end
        checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL %s wait_rd_hold got=%h exp=%h", tag, rd_data, last_rd); end
        tick();
        if (w == rv_dly) break;
      end
      mem_rvalid = 1'b0;
      if (rv_dly >= TO) begin
        exp_err = 1'b1;
        last_rd = 32'd0;
      end else begin
        last_rd = m_load(sz, uns, a, rdata);
      end
    end

    @(negedge clk);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s done got=%b exp=1", tag, done); end
    checks++; if (bus_err !== exp_err) begin errors++; $display("FAIL %s bus_err got=%b exp=%b", tag, bus_err, exp_err); end
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL %s done_stall_req got=%b%b exp=00", tag, stall, mem_req); end
    checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL %s rd_data got=%h exp=%h", tag, rd_data, last_rd); end
    checks++; if (mem_addr !== exp_addr || mem_be !== exp_be) begin errors++; $display("FAIL %s done_hold addr=%h be=%b exp=%h %b", tag, mem_addr, mem_be, exp_addr, exp_be); end
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || bus_err !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL %s after done/err/stall got=%b%b%b exp=000", tag, done, bus_err, stall); end
    checks++; if (rd_data !== last_rd) begin errors++; $display("FAIL %s after_rd_hold got=%h exp=%h", tag, rd_data, last_rd); end
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || done !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset ctl got=%b%b%b%b exp=0000", mem_req, mem_we, done, bus_err); end
    checks++; if (mem_addr !== 32'd0 || mem_be !== 4'd0 || mem_wdata !== 32'd0) begin errors++; $display("FAIL reset bus got=%h %b %h exp=0", mem_addr, mem_be, mem_wdata); end
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL reset rd_data got=%h exp=0", rd_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset stall got=%b exp=0", stall); end
    rst = 1'b0;
    last_rd = 32'd0;
    tick();
  endtask

  task automatic test_store_byte();
    run_access(1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'hAB, 32'd0, 0, 0, "sb");
    checks++; if (mem_be !== 4'b0100 || mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h100) begin errors++; $display("FAIL sb_vec got be=%b wd=%h a=%h exp=0100 abababab 100", mem_be, mem_wdata, mem_addr); end
  endtask

  task automatic test_load_half();
    run_access(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'd0, 32'h8001_0000, 3, 2, "lh");
    checks++; if (rd_data !== 32'hFFFF_8001 || mem_be !== 4'b1100) begin errors++; $display("FAIL lh_vec got rd=%h be=%b exp=ffff8001 1100", rd_data, mem_be); end
  endtask

  task automatic test_load_byte_unsigned();
    run_access(1'b1, 1'b0, 2'b00, 1'b1, 32'h3, 32'd0, 32'hF200_0000, 0, 0, "lbu");
    checks++; if (rd_data !== 32'h0000_00F2) begin errors++; $display("FAIL lbu_vec got=%h exp=000000f2", rd_data); end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'd0, 32'h1234_5678, 0, TO - 1, "rv_last");
    checks++; if (rd_data !== 32'h1234_5678) begin errors++; $display("FAIL rv_last_vec got=%h exp=12345678", rd_data); end
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'd0, 32'hDEAD_BEEF, 1, 1000, "timeout");
    checks++; if (rd_data !== 32'd0) begin errors++; $display("FAIL timeout_vec got=%h exp=0", rd_data); end
  endtask

  task automatic test_rd_wr_both();
    run_access(1'b1, 1'b1, 2'b11, 1'b0, 32'h88, 32'h5555_5555, 32'hCAFE_F00D, 0, 1, "both");
    checks++; if (mem_we !== 1'b0 || rd_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL both_vec got we=%b rd=%h exp=0 cafef00d", mem_we, rd_data); end
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    rd_en = 1'b1; size = 2'b10; addr = 32'h1001; ld_unsigned = 1'b0;
    @(negedge clk);
    checks++; if (stall !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL trap idle stall/req got=%b%b exp=00", stall, mem_req); end
    tick();
    rd_en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b1 || misalign_err !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL trap pulse done/err/req got=%b%b%b exp=110", done, misalign_err, mem_req); end
    tick();
    @(negedge clk);
    checks++; if (done !== 1'b0 || misalign_err !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL trap after done/err/req got=%b%b%b exp=000", done, misalign_err, mem_req); end
    tick();
`else
    run_access(1'b1, 1'b0, 2'b10, 1'b0, 32'h1001, 32'd0, 32'h0BAD_F00D, 0, 0, "mis_w");
    checks++; if (mem_addr !== 32'h1000 || mem_be !== 4'b1111) begin errors++; $display("FAIL mis_w_vec got a=%h be=%b exp=1000 1111", mem_addr, mem_be); end
    run_access(1'b0, 1'b1, 2'b01, 1'b0, 32'h2003, 32'h0000_BEEF, 32'd0, 1, 0, "mis_h");
    checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL mis_h_vec got be=%b wd=%h exp=1100 beefbeef", mem_be, mem_wdata); end
`endif
  endtask

  task automatic test_reset_mid_wait();
    rd_en = 1'b1; wr_en = 1'b0; size = 2'b10; addr = 32'h300; ld_unsigned = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstwait pre_stall got=%b exp=1", stall); end
    rst = 1'b1;
    rd_en = 1'b0;
    tick();
    rst = 1'b0;
    last_rd = 32'd0;
    for (int i = 0; i < 4; i++) begin
      mem_rvalid = (i < 2);
      mem_gnt    = (i == 1);
      mem_rdata  = $urandom();
      @(negedge clk);
      checks++; if (done !== 1'b0 || mem_req !== 1'b0 || stall !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rstwait idle done/req/stall/err got=%b%b%b%b exp=0000", done, mem_req, stall, bus_err); end
      tick();
    end
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b0;
    checks++; if (rd_data !== 32'd0 || mem_addr !== 32'd0) begin errors++; $display("FAIL rstwait regs got rd=%h a=%h exp=0 0", rd_data, mem_addr); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 2));
      a  = $urandom();
      if (TRAP) a = a & ~32'h3;
      run_access(op != 1, op != 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 a, $urandom(), $urandom(), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, TO + 1)), "rand");
    end
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0; size = 2'b00; ld_unsigned = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    last_rd = 32'd0;
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_byte_unsigned();
    test_timeout();
    test_rd_wr_both();
    test_misalign();
    test_reset_mid_wait();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
